// File: rtl/bin_to_gray.sv
// Registered binary-to-reflected-Gray converter with a configurable output pipeline.
// Accepts a word every cycle; gray_data is driven straight from the last register stage.
module bin_to_gray #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned PIPE_STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] gray_data
);

   logic [WIDTH-1:0] gray_d;
   logic [WIDTH-1:0] pipe_q [PIPE_STAGES];

   always_comb begin
      gray_d = data ^ (data >> 1);
   end

   // Asynchronous clear drops every in-flight value at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_STAGES; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= gray_d;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign gray_data = pipe_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_bin_to_gray.sv
// Directed bench for bin_to_gray: single-stage and three-stage instances share stimulus,
// with per-instance scoreboard queues of expected Gray words.
module tb_bin_to_gray;

   logic       clk;
   logic       rst;
   logic [3:0] data;
   logic [3:0] gray1;
   logic [3:0] gray3;

   int n_checks = 0;
   int n_err    = 0;

   logic [3:0] q1 [$];
   logic [3:0] q3 [$];

   logic [3:0] tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   bin_to_gray #(.WIDTH(4), .PIPE_STAGES(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .gray_data (gray1)
   );

   bin_to_gray #(.WIDTH(4), .PIPE_STAGES(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .gray_data (gray3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] model_gray(input logic [3:0] b);
      logic [3:0] g;
      g[3] = b[3];
      for (int i = 0; i < 3; i++) g[i] = b[i+1] ^ b[i];
      return g;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [3:0] obs, inout logic [3:0] q [$]);
      if (q.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
      end else begin
         check(tag, {28'd0, obs}, {28'd0, q.pop_front()});
      end
   endtask

   // Drive one word, clock it in, then compare both instances against their queues.
   task automatic step(input logic [3:0] v);
      data = v;
      q1.push_back(model_gray(v));
      q3.push_back(model_gray(v));
      @(posedge clk);
      #1;
      pop_check("pipe1", gray1, q1);
      pop_check("pipe3", gray3, q3);
      @(negedge clk);
   endtask

   task automatic restart_queues();
      q1.delete();
      q3.delete();
      q3.push_back(4'h0);
      q3.push_back(4'h0);
   endtask

   initial begin
      logic [3:0] prev;
      logic [3:0] hold;

      rst  = 1'b1;
      data = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_held_p1", {28'd0, gray1}, 32'd0);
         check("reset_held_p3", {28'd0, gray3}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      restart_queues();

      // Exhaustive sweep plus single-bit-change across 0..15 and the wrap to 0.
      for (int i = 0; i < 16; i++) begin
         step(4'(i));
         check("sweep_table", {28'd0, gray1}, {28'd0, tab[i]});
         if (i > 0) check("one_bit_change", 32'($countones(gray1 ^ prev)), 32'd1);
         prev = gray1;
      end
      step(4'h0);
      check("wrap_one_bit", 32'($countones(gray1 ^ prev)), 32'd1);
      check("wrap_value", {28'd0, gray1}, 32'd0);

      // Latency of the three-stage instance right after reset release.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      @(negedge clk);
      restart_queues();
      step(4'h9);
      check("lat3_edge1", {28'd0, gray3}, 32'd0);
      step(4'hC);
      check("lat3_edge2", {28'd0, gray3}, 32'd0);
      step(4'h0);
      check("lat3_first", {28'd0, gray3}, 32'hD);
      step(4'h0);
      check("lat3_second", {28'd0, gray3}, 32'hA);

      // Held and sparse stimulus.
      for (int r = 0; r < 50; r++) begin
         hold = 4'($urandom_range(15));
         for (int c = 0; c < 50; c++) step(hold);
         for (int c = 0; c < 30; c++) step(4'h0);
      end

      // Asynchronous reset between edges while the output shows 8.
      step(4'hF);
      check("pre_async_val", {28'd0, gray1}, 32'h8);
      data = 4'h6;
      #1;
      rst = 1'b1;
      #1;
      check("async_clear_p1", {28'd0, gray1}, 32'd0);
      check("async_clear_p3", {28'd0, gray3}, 32'd0);
      rst = 1'b0;
      restart_queues();
      step(4'h6);
      check("post_reset_val", {28'd0, gray1}, 32'h5);
      step(4'h6);
      step(4'h6);
      check("post_reset_p3", {28'd0, gray3}, 32'h5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/bin_to_gray.md
# bin_to_gray

Registered binary-to-Gray-code converter.
- Accepts an unsigned binary word every clock cycle and presents its reflected-binary Gray encoding on a registered output after a fixed latency.
- Sits between binary counters or pointers and any consumer that needs single-bit-change encoding, e.g. clock-domain-crossing pointer paths or encoder/display logic.
- Fully pipelined: a new input is accepted every cycle, with no handshake.

## Interface

Parameters:
- WIDTH, default 4: bit width of the binary input and the Gray output; must be ≥ 1.
- PIPE_STAGES, default 1: number of output register stages (latency in cycles); must be ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all pipeline registers.
- data  input  WIDTH  unsigned binary value to convert; sampled on every rising clk edge.
- gray_data  output  WIDTH  Gray code of data sampled PIPE_STAGES cycles earlier; driven directly from a register.

## Operation

- Conversion function, combinational, applied to the sampled input:
  - gray[WIDTH-1] = data[WIDTH-1]
  - gray[i] = data[i+1] XOR data[i], for i = WIDTH-2 down to 0
  - Equivalent to gray = data XOR (data >> 1), logical shift.
- Result passes through a shift pipeline of PIPE_STAGES registers, each WIDTH bits wide. gray_data is the last stage.
- No enable and no valid signal: every cycle, a new input is converted and accepted.
- Mapping is bijective over 0 to 2^WIDTH−1. For WIDTH=4:
  - 0→0, 1→1, 2→3, 3→2, 4→6, 5→7, 6→5, 7→4
  - 8→C, 9→D, A→F, B→E, C→A, D→B, E→9, F→8
- Consecutive binary inputs n and n+1 must give outputs differing in exactly one bit. This includes the wrap from 2^WIDTH−1 to 0, e.g. 8→0 for WIDTH=4.
- No arithmetic overflow is possible; the output width always equals the input width.
- X or Z on data propagates to gray_data per the XOR equations. No special handling.

## Timing

- Reset:
  - While rst=1, every pipeline register and gray_data equal 0.
  - Clearing is asynchronous: it takes effect immediately on assertion, without waiting for clk.
- Reset release:
  - The first rising clk edge with rst=0 loads stage 1 from the current data.
  - gray_data stays 0 until PIPE_STAGES edges have occurred after release.
- Latency: data sampled at rising edge k appears on gray_data just after rising edge k+PIPE_STAGES−1. For PIPE_STAGES=1, it is valid right after the sampling edge.
- Throughput: one conversion per cycle; back-to-back changes are all preserved.
- Reset asserted mid-stream: in-flight values are discarded and gray_data goes to 0 at once. After release, only newly sampled data is output.
- data changing between edges has no effect on gray_data until the next rising edge.
- No combinational path from data to gray_data.

## Test plan

- Reset: hold rst=1 with data=4'hF and clk toggling → gray_data=0 throughout. Assert rst asynchronously between edges while gray_data=8 → gray_data=0 immediately, before the next edge.
- Exhaustive sweep, WIDTH=4, PIPE_STAGES=1: drive data 0..15, one per cycle → gray_data follows the table one edge later (e.g. 2→3, 7→4, 10→F, 15→8).
- Single-bit-change property: count data 0→15→0 → each successive gray_data differs from the previous in exactly one bit, including F→0 (8→0).
- Held and sparse stimulus: hold a random 4-bit value (e.g. 5) for 50 cycles, then 0 for 30 cycles; repeat 50 times → gray_data is 7 for the hold window, then 0, with one-cycle lag at each change.
- Latency, PIPE_STAGES=3: after reset release, drive 9 then 12 on consecutive edges → gray_data stays 0 for the first 2 edges, then shows D then A on successive cycles.
- Mid-stream reset: pulse rst for 2 ns while converting data=6 → gray_data=0 during the pulse; the first post-release edge with data=6 restores gray_data=5.
